wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order WB stage and a
//  long-latency unit (LLU: mul/div, load-miss return). WB stage always wins; LLU
//  results wait in a small FIFO and drain into idle slots. Starvation counter requests
//  a pipeline bubble. Sits between WB stage / LLU and the register file write port.
// PARAMETERS
//  DATA_W    32  register data width
//  ADDR_W    5   register index width
//  DEPTH     2   LLU result FIFO entries (power of two, >=2)
//  MAX_WAIT  4   consecutive lost arbitrations before StallReq asserts
// PORTS
//  Clk         in   1       clock; all state updates on negedge Clk (matches WB stage)
//  Reset_n     in   1       asynchronous, active-low reset
//  WBRd        in   ADDR_W  WB stage destination register
//  WBData      in   DATA_W  WB stage write data
//  WBRegWrite  in   1       WB stage write request
//  LluValid    in   1       LLU result valid
//  LluRd       in   ADDR_W  LLU destination register
//  LluData     in   DATA_W  LLU result data
//  LluReady    out  1       arbiter can accept LLU result
//  RfWe        out  1       register-file write enable (registered)
//  RfWaddr     out  ADDR_W  register-file write address (registered)
//  RfWdata     out  DATA_W  register-file write data (registered)
//  StallReq    out  1       request hazard unit to insert one WB bubble (registered)
//  LluPending  out  1       FIFO non-empty (for scoreboard)
// BEHAVIOUR
//  - Reset (Reset_n low, async): RfWe/RfWaddr/RfWdata/StallReq=0, FIFO empty, pointers
//    and WaitCnt=0, LluReady=0, LluPending=0. Reset mid-drain drops FIFO contents.
//  - Pipe request = WBRegWrite && WBRd!=0; WBRd==0 writes are suppressed (RfWe=0).
//  - LluReady = Reset_n && (count<DEPTH); combinational from registered count.
//    LLU accept on edge where LluValid&&LluReady; LluRd==0 accepted and discarded.
//  - Grant per negedge, priority: (1) pipe request -> Rf* = WB inputs;
//    (2) FIFO non-empty -> pop head to Rf*; (3) FIFO empty and LLU accept with
//    LluRd!=0 -> bypass straight to Rf* (no push); (4) else RfWe=0, addr/data hold.
//  - Write latency: one negedge from request to Rf* outputs for all sources.
//  - Accept while pipe wins or FIFO non-empty -> push at tail. Push+pop same edge
//    legal (count unchanged). No push when full (LluReady=0). Pointers wrap mod DEPTH.
//  - FIFO order strict; LLU results never reorder among themselves.
//  - WaitCnt: increments (saturating at MAX_WAIT) on edges where pipe wins while FIFO
//    non-empty or LLU valid; clears on any LLU grant (pop or bypass).
//  - StallReq=1 while WaitCnt==MAX_WAIT; clears the edge after an LLU grant. Pipe
//    still wins if it requests anyway; StallReq is advisory.
//  - WAW ordering vs pipe writes is guaranteed upstream by scoreboard via LluPending;
//    bench asserts no pipe write to an Rd present in FIFO.
//  - LluPending = (count!=0).
// STRUCTURE
//  - Package wb_arb_pkg: DATA_W, ADDR_W defaults, ZERO_REG=0, grant-source encoding
//    (GNT_NONE, GNT_PIPE, GNT_FIFO, GNT_BYP).
//  - Sub-module wb_llu_fifo: DEPTH-entry {rd,data} FIFO, push/pop/full/empty/count,
//    negedge clocked, async active-low reset. Arbiter top holds grant mux, WaitCnt,
//    output registers.
// TESTING
//  1 Reset: Reset_n=0 mid-stream with 2 FIFO entries -> all outputs 0, LluReady=0;
//    release -> LluReady=1, LluPending=0.
//  2 Bypass: idle pipe, LluValid Rd=7 Data=0xDEAD_BEEF -> next negedge RfWe=1,
//    RfWaddr=7, RfWdata=0xDEADBEEF, LluPending stays 0.
//  3 Contention: pipe writes Rd=3 every cycle, LLU sends Rd=9,10,11 -> 9,10 queued,
//    LluReady=0 on third; pipe drops -> Rf writes 9 then 10 then 11 in order.
//  4 Starvation: FIFO holds Rd=5, pipe writes 4 consecutive cycles -> StallReq=1
//    after 4th; pipe idle one cycle -> Rd=5 written, StallReq=0 next edge.
//  5 Zero reg: WBRegWrite=1 WBRd=0, LLU Rd=0 -> RfWe=0, LLU handshake completes,
//    FIFO count unchanged.
//  6 Push+pop: FIFO count=1, pipe idle, LLU valid Rd=12 -> head popped, Rd=12 pushed,
//    count stays 1, written next idle slot.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared widths, reserved register index and grant-source encoding for the
// register-file write-port arbiter.
package wb_arb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 0;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_FIFO = 2'd2,
        GNT_BYP  = 2'd3
    } gnt_src_t;

endpackage

// File: rtl/wb_llu_fifo.sv
// In-order queue of {rd,data} long-latency results waiting for a free write slot.
// Clocked on the falling edge to line up with the WB stage.
module wb_llu_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   push,
    input  logic [ADDR_W-1:0]      push_rd,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic [ADDR_W-1:0]      head_rd,
    output logic [DATA_W-1:0]      head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_rd   = rd_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(negedge Clk) begin
        if (do_push) begin
            rd_mem[wr_ptr]   <= push_rd;
            data_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(negedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)
                count <= count + CNT_W'(1);
            else if (!do_push && do_pop)
                count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage (always wins) and
// long-latency results, which queue and drain into idle slots.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_W   = wb_arb_pkg::DATA_W,
    parameter int ADDR_W   = wb_arb_pkg::ADDR_W,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] WBRd,
    input  logic [DATA_W-1:0] WBData,
    input  logic              WBRegWrite,
    input  logic              LluValid,
    input  logic [ADDR_W-1:0] LluRd,
    input  logic [DATA_W-1:0] LluData,
    output logic              LluReady,
    output logic              RfWe,
    output logic [ADDR_W-1:0] RfWaddr,
    output logic [DATA_W-1:0] RfWdata,
    output logic              StallReq,
    output logic              LluPending
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic              pipe_req;
    logic              llu_accept;
    logic              llu_keep;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0] head_data;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    gnt_src_t          grant;

    assign pipe_req   = WBRegWrite && (WBRd != ADDR_W'(ZERO_REG));
    assign LluReady   = Reset_n && (fifo_count < CNT_W'(DEPTH));
    assign LluPending = !fifo_empty;
    assign llu_accept = LluValid && LluReady;
    // Results for the zero register complete the handshake but are dropped.
    assign llu_keep   = llu_accept && (LluRd != ADDR_W'(ZERO_REG));

    // Queued results go before a fresh one so LLU writes never reorder.
    always_comb begin
        grant = GNT_NONE;
        if (pipe_req)
            grant = GNT_PIPE;
        else if (!fifo_empty)
            grant = GNT_FIFO;
        else if (llu_keep)
            grant = GNT_BYP;
    end

    assign fifo_pop  = (grant == GNT_FIFO);
    assign fifo_push = llu_keep && (grant == GNT_PIPE || grant == GNT_FIFO);

    always_comb begin
        wait_nxt = wait_cnt;
        if (grant == GNT_FIFO || grant == GNT_BYP)
            wait_nxt = '0;
        else if (grant == GNT_PIPE && (!fifo_empty || LluValid)
                 && wait_cnt != WAIT_W'(MAX_WAIT))
            wait_nxt = wait_cnt + WAIT_W'(1);
    end

    wb_llu_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .push      (fifo_push),
        .push_rd   (LluRd),
        .push_data (LluData),
        .pop       (fifo_pop),
        .head_rd   (head_rd),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Address and data hold their last value on idle slots; only RfWe drops.
    always_ff @(negedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            RfWe     <= 1'b0;
            RfWaddr  <= '0;
            RfWdata  <= '0;
            StallReq <= 1'b0;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_nxt;
            StallReq <= (wait_nxt == WAIT_W'(MAX_WAIT));
            case (grant)
                GNT_PIPE: begin
                    RfWe    <= 1'b1;
                    RfWaddr <= WBRd;
                    RfWdata <= WBData;
                end
                GNT_FIFO: begin
                    RfWe    <= 1'b1;
                    RfWaddr <= head_rd;
                    RfWdata <= head_data;
                end
                GNT_BYP: begin
                    RfWe    <= 1'b1;
                    RfWaddr <= LluRd;
                    RfWdata <= LluData;
                end
                default: RfWe <= 1'b0;
            endcase
        end
    end

endmodule
